c7bbiu_arbiter: RTL and testbench

- Request arbiter and transaction tracker feeding the BIU AXI interface stage.
- Accepts level-held read requests from IFU and read/write requests from LSU.
- Grants one transaction at a time with round-robin fairness between IFU and LSU, then drives the registered arb_rd_*/arb_wr_* request bus.
- Holds the request in a wait state until the AXI stage reports completion or a timeout expires.

---
 rtl/c7bbiu_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_c7bbiu_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/c7bbiu_arbiter.sv
// Round-robin IFU/LSU request arbiter and single-transaction tracker for the BIU AXI stage.
// Grant and request bus are registered one cycle after arbitration; new requests wait in IDLE until the outstanding one completes or times out.
module c7bbiu_arbiter #(
  parameter logic [3:0]  RID_IFU     = 4'h0,
  parameter logic [3:0]  RID_LSU     = 4'h1,
  parameter logic [7:0]  IFU_RD_LEN  = 8'd0,
  parameter logic [15:0] TIMEOUT_CYC = 16'd1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ifu_biu_rd_req,
  input  logic [31:0] ifu_biu_rd_addr,
  input  logic        lsu_biu_rd_req,
  input  logic [31:0] lsu_biu_rd_addr,
  input  logic [2:0]  lsu_biu_rd_size,
  input  logic        lsu_biu_wr_req,
  input  logic [31:0] lsu_biu_wr_addr,
  input  logic [2:0]  lsu_biu_wr_size,
  input  logic [31:0] lsu_biu_wr_data,
  input  logic [3:0]  lsu_biu_wr_strb,
  input  logic        axi_rdata_ifu_val,
  input  logic        axi_rdata_lsu_val,
  input  logic        axi_write_lsu_val,
  output logic        biu_ifu_rd_gnt,
  output logic        biu_lsu_rd_gnt,
  output logic        biu_lsu_wr_gnt,
  output logic        arb_rd_val,
  output logic [3:0]  arb_rd_id,
  output logic [31:0] arb_rd_addr,
  output logic [1:0]  arb_rd_burst,
  output logic [7:0]  arb_rd_len,
  output logic [2:0]  arb_rd_size,
  output logic        arb_rd_lock,
  output logic [3:0]  arb_rd_cache,
  output logic [2:0]  arb_rd_prot,
  output logic        arb_wr_val,
  output logic [3:0]  arb_wr_id,
  output logic [31:0] arb_wr_addr,
  output logic [7:0]  arb_wr_len,
  output logic [2:0]  arb_wr_size,
  output logic [31:0] arb_wr_data,
  output logic [3:0]  arb_wr_strb,
  output logic        arb_wr_last,
  output logic        biu_timeout,
  output logic        biu_proto_err
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RD_IFU = 2'd1;
  localparam logic [1:0] ST_RD_LSU = 2'd2;
  localparam logic [1:0] ST_WR_LSU = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        last_lsu_q, last_lsu_d;
  logic [15:0] cnt_q, cnt_d;
  logic        gnt_ifu_q, gnt_ifu_d, gnt_rd_q, gnt_rd_d, gnt_wr_q, gnt_wr_d;
  logic        rd_val_q, rd_val_d, wr_val_q, wr_val_d;
  logic        timeout_q, timeout_d, err_q, err_d;
  logic [3:0]  rd_id_q, rd_id_d;
  logic [31:0] rd_addr_q, rd_addr_d;
  logic [1:0]  rd_burst_q, rd_burst_d;
  logic [7:0]  rd_len_q, rd_len_d;
  logic [2:0]  rd_size_q, rd_size_d;
  logic [3:0]  wr_id_q, wr_id_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [2:0]  wr_size_q, wr_size_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic [3:0]  wr_strb_q, wr_strb_d;
  logic        wr_last_q, wr_last_d;

  logic lsu_req, pick_ifu, pick_wr, pick_rd, cmp_match, stray, timeout_hit;

  always_comb begin
    lsu_req   = lsu_biu_wr_req | lsu_biu_rd_req;
    // Tie goes to whichever class was not granted last
    pick_ifu  = ifu_biu_rd_req & (~lsu_req | last_lsu_q);
    pick_wr   = ~pick_ifu & lsu_biu_wr_req;
    pick_rd   = ~pick_ifu & ~lsu_biu_wr_req & lsu_biu_rd_req;
    cmp_match = ((state_q == ST_RD_IFU) & axi_rdata_ifu_val) |
                ((state_q == ST_RD_LSU) & axi_rdata_lsu_val) |
                ((state_q == ST_WR_LSU) & axi_write_lsu_val);
    stray     = ((state_q != ST_RD_IFU) & axi_rdata_ifu_val) |
                ((state_q != ST_RD_LSU) & axi_rdata_lsu_val) |
                ((state_q != ST_WR_LSU) & axi_write_lsu_val);
    timeout_hit = (TIMEOUT_CYC != 16'd0) && (cnt_q == (TIMEOUT_CYC - 16'd1));
  end

  always_comb begin
    state_d    = state_q;
    last_lsu_d = last_lsu_q;
    cnt_d      = cnt_q;
    gnt_ifu_d  = 1'b0;
    gnt_rd_d   = 1'b0;
    gnt_wr_d   = 1'b0;
    rd_val_d   = 1'b0;
    wr_val_d   = 1'b0;
    timeout_d  = 1'b0;
    err_d      = err_q | stray;
    rd_id_d    = rd_id_q;
    rd_addr_d  = rd_addr_q;
    rd_burst_d = rd_burst_q;
    rd_len_d   = rd_len_q;
    rd_size_d  = rd_size_q;
    wr_id_d    = wr_id_q;
    wr_addr_d  = wr_addr_q;
    wr_size_d  = wr_size_q;
    wr_data_d  = wr_data_q;
    wr_strb_d  = wr_strb_q;
    wr_last_d  = wr_last_q;
    if (state_q == ST_IDLE) begin
      cnt_d = 16'd0;
      if (pick_ifu) begin
        state_d    = ST_RD_IFU;
        last_lsu_d = 1'b0;
        gnt_ifu_d  = 1'b1;
        rd_val_d   = 1'b1;
        rd_id_d    = RID_IFU;
        rd_addr_d  = ifu_biu_rd_addr;
        rd_burst_d = 2'b01;
        rd_len_d   = IFU_RD_LEN;
        rd_size_d  = 3'b010;
      end else if (pick_wr) begin
        state_d    = ST_WR_LSU;
        last_lsu_d = 1'b1;
        gnt_wr_d   = 1'b1;
        wr_val_d   = 1'b1;
        wr_id_d    = 4'h1;
        wr_addr_d  = lsu_biu_wr_addr;
        wr_size_d  = lsu_biu_wr_size;
        wr_data_d  = lsu_biu_wr_data;
        wr_strb_d  = lsu_biu_wr_strb;
        wr_last_d  = 1'b1;
      end else if (pick_rd) begin
        state_d    = ST_RD_LSU;
        last_lsu_d = 1'b1;
        gnt_rd_d   = 1'b1;
        rd_val_d   = 1'b1;
        rd_id_d    = RID_LSU;
        rd_addr_d  = lsu_biu_rd_addr;
        rd_burst_d = 2'b01;
        rd_len_d   = 8'd0;
        rd_size_d  = lsu_biu_rd_size;
      end
    end else if (cmp_match) begin
      state_d = ST_IDLE;
    end else if (timeout_hit) begin
      state_d   = ST_IDLE;
      timeout_d = 1'b1;
    end else if (cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      last_lsu_q <= 1'b1;
      cnt_q      <= 16'd0;
      gnt_ifu_q  <= 1'b0;
      gnt_rd_q   <= 1'b0;
      gnt_wr_q   <= 1'b0;
      rd_val_q   <= 1'b0;
      wr_val_q   <= 1'b0;
      timeout_q  <= 1'b0;
      err_q      <= 1'b0;
      rd_id_q    <= 4'h0;
      rd_addr_q  <= 32'h0;
      rd_burst_q <= 2'b00;
      rd_len_q   <= 8'h0;
      rd_size_q  <= 3'b000;
      wr_id_q    <= 4'h0;
      wr_addr_q  <= 32'h0;
      wr_size_q  <= 3'b000;
      wr_data_q  <= 32'h0;
      wr_strb_q  <= 4'h0;
      wr_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_lsu_q <= last_lsu_d;
      cnt_q      <= cnt_d;
      gnt_ifu_q  <= gnt_ifu_d;
      gnt_rd_q   <= gnt_rd_d;
      gnt_wr_q   <= gnt_wr_d;
      rd_val_q   <= rd_val_d;
      wr_val_q   <= wr_val_d;
      timeout_q  <= timeout_d;
      err_q      <= err_d;
      rd_id_q    <= rd_id_d;
      rd_addr_q  <= rd_addr_d;
      rd_burst_q <= rd_burst_d;
      rd_len_q   <= rd_len_d;
      rd_size_q  <= rd_size_d;
      wr_id_q    <= wr_id_d;
      wr_addr_q  <= wr_addr_d;
      wr_size_q  <= wr_size_d;
      wr_data_q  <= wr_data_d;
      wr_strb_q  <= wr_strb_d;
      wr_last_q  <= wr_last_d;
    end
  end

  assign biu_ifu_rd_gnt = gnt_ifu_q;
  assign biu_lsu_rd_gnt = gnt_rd_q;
  assign biu_lsu_wr_gnt = gnt_wr_q;
  assign arb_rd_val     = rd_val_q;
  assign arb_rd_id      = rd_id_q;
  assign arb_rd_addr    = rd_addr_q;
  assign arb_rd_burst   = rd_burst_q;
  assign arb_rd_len     = rd_len_q;
  assign arb_rd_size    = rd_size_q;
  assign arb_rd_lock    = 1'b0;
  assign arb_rd_cache   = 4'h0;
  assign arb_rd_prot    = 3'b000;
  assign arb_wr_val     = wr_val_q;
  assign arb_wr_id      = wr_id_q;
  assign arb_wr_addr    = wr_addr_q;
  assign arb_wr_len     = 8'd0;
  assign arb_wr_size    = wr_size_q;
  assign arb_wr_data    = wr_data_q;
  assign arb_wr_strb    = wr_strb_q;
  assign arb_wr_last    = wr_last_q;
  assign biu_timeout    = timeout_q;
  assign biu_proto_err  = err_q;

endmodule

// File: tb/tb_c7bbiu_arbiter.sv
// Directed bench for c7bbiu_arbiter: contention, single read, write hold/priority, timeout, async reset.
module tb_c7bbiu_arbiter;
  logic        clk = 1'b0;
  logic        resetn;
  logic        ifu_biu_rd_req;
  logic [31:0] ifu_biu_rd_addr;
  logic        lsu_biu_rd_req;
  logic [31:0] lsu_biu_rd_addr;
  logic [2:0]  lsu_biu_rd_size;
  logic        lsu_biu_wr_req;
  logic [31:0] lsu_biu_wr_addr;
  logic [2:0]  lsu_biu_wr_size;
  logic [31:0] lsu_biu_wr_data;
  logic [3:0]  lsu_biu_wr_strb;
  logic        axi_rdata_ifu_val, axi_rdata_lsu_val, axi_write_lsu_val;
  logic        biu_ifu_rd_gnt, biu_lsu_rd_gnt, biu_lsu_wr_gnt;
  logic        arb_rd_val;
  logic [3:0]  arb_rd_id;
  logic [31:0] arb_rd_addr;
  logic [1:0]  arb_rd_burst;
  logic [7:0]  arb_rd_len;
  logic [2:0]  arb_rd_size;
  logic        arb_rd_lock;
  logic [3:0]  arb_rd_cache;
  logic [2:0]  arb_rd_prot;
  logic        arb_wr_val;
  logic [3:0]  arb_wr_id;
  logic [31:0] arb_wr_addr;
  logic [7:0]  arb_wr_len;
  logic [2:0]  arb_wr_size;
  logic [31:0] arb_wr_data;
  logic [3:0]  arb_wr_strb;
  logic        arb_wr_last;
  logic        biu_timeout, biu_proto_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  c7bbiu_arbiter #(.TIMEOUT_CYC(16'd8)) dut (
    .clk(clk), .resetn(resetn),
    .ifu_biu_rd_req(ifu_biu_rd_req), .ifu_biu_rd_addr(ifu_biu_rd_addr),
    .lsu_biu_rd_req(lsu_biu_rd_req), .lsu_biu_rd_addr(lsu_biu_rd_addr),
    .lsu_biu_rd_size(lsu_biu_rd_size),
    .lsu_biu_wr_req(lsu_biu_wr_req), .lsu_biu_wr_addr(lsu_biu_wr_addr),
    .lsu_biu_wr_size(lsu_biu_wr_size), .lsu_biu_wr_data(lsu_biu_wr_data),
    .lsu_biu_wr_strb(lsu_biu_wr_strb),
    .axi_rdata_ifu_val(axi_rdata_ifu_val), .axi_rdata_lsu_val(axi_rdata_lsu_val),
    .axi_write_lsu_val(axi_write_lsu_val),
    .biu_ifu_rd_gnt(biu_ifu_rd_gnt), .biu_lsu_rd_gnt(biu_lsu_rd_gnt),
    .biu_lsu_wr_gnt(biu_lsu_wr_gnt),
    .arb_rd_val(arb_rd_val), .arb_rd_id(arb_rd_id), .arb_rd_addr(arb_rd_addr),
    .arb_rd_burst(arb_rd_burst), .arb_rd_len(arb_rd_len), .arb_rd_size(arb_rd_size),
    .arb_rd_lock(arb_rd_lock), .arb_rd_cache(arb_rd_cache), .arb_rd_prot(arb_rd_prot),
    .arb_wr_val(arb_wr_val), .arb_wr_id(arb_wr_id), .arb_wr_addr(arb_wr_addr),
    .arb_wr_len(arb_wr_len), .arb_wr_size(arb_wr_size), .arb_wr_data(arb_wr_data),
    .arb_wr_strb(arb_wr_strb), .arb_wr_last(arb_wr_last),
    .biu_timeout(biu_timeout), .biu_proto_err(biu_proto_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Grant pulses packed as {ifu, lsu_rd, lsu_wr, rd_val, wr_val}
  function automatic logic [31:0] gnts();
    return {27'd0, biu_ifu_rd_gnt, biu_lsu_rd_gnt, biu_lsu_wr_gnt, arb_rd_val, arb_wr_val};
  endfunction

  initial begin
    resetn = 1'b0;
    ifu_biu_rd_req = 0; ifu_biu_rd_addr = 32'h1C000000;
    lsu_biu_rd_req = 0; lsu_biu_rd_addr = 32'h80000100; lsu_biu_rd_size = 3'd1;
    lsu_biu_wr_req = 0; lsu_biu_wr_addr = 32'h0; lsu_biu_wr_size = 3'd0;
    lsu_biu_wr_data = 32'h0; lsu_biu_wr_strb = 4'h0;
    axi_rdata_ifu_val = 0; axi_rdata_lsu_val = 0; axi_write_lsu_val = 0;
    tick(); tick();
    chk("reset_gnts", gnts(), 32'h0);
    chk("reset_rd_burst", {30'd0, arb_rd_burst}, 32'h0);
    chk("reset_wr_last", {31'd0, arb_wr_last}, 32'h0);
    chk("reset_err_to", {30'd0, biu_proto_err, biu_timeout}, 32'h0);

    // Contention from reset: IFU wins first, then strict alternation
    ifu_biu_rd_req = 1; lsu_biu_rd_req = 1;
    resetn = 1'b1;
    tick();
    chk("cont1_gnts", gnts(), 32'b10010);
    chk("cont1_id", {28'd0, arb_rd_id}, 32'h0);
    chk("cont1_addr", arb_rd_addr, 32'h1C000000);
    chk("cont1_len_size_burst", {19'd0, arb_rd_len, arb_rd_size, arb_rd_burst}, {19'd0, 8'd0, 3'd2, 2'd1});
    tick();
    chk("cont1_pulse_end", gnts(), 32'h0);
    axi_rdata_ifu_val = 1; tick(); axi_rdata_ifu_val = 0;
    chk("cont1_idle_gap", gnts(), 32'h0);
    tick();
    chk("cont2_gnts", gnts(), 32'b01010);
    chk("cont2_id_size", {25'd0, arb_rd_id, arb_rd_size}, {25'd0, 4'h1, 3'd1});
    chk("cont2_addr_len", {arb_rd_addr[23:0], arb_rd_len}, {24'h000100, 8'd0});
    axi_rdata_lsu_val = 1; tick(); axi_rdata_lsu_val = 0;
    tick();
    chk("cont3_gnts", gnts(), 32'b10010);
    axi_rdata_ifu_val = 1; tick(); axi_rdata_ifu_val = 0;
    ifu_biu_rd_req = 0; lsu_biu_rd_req = 0;
    lsu_biu_rd_size = 3'd2; lsu_biu_rd_addr = 32'h80000200;
    lsu_biu_rd_req = 1;
    tick();
    chk("cont4_gnts", gnts(), 32'b01010);
    chk("cont4_addr", arb_rd_addr, 32'h80000200);
    lsu_biu_rd_req = 0;
    axi_rdata_lsu_val = 1; tick(); axi_rdata_lsu_val = 0;
    tick(); tick();
    chk("idle_quiet", gnts(), 32'h0);
    chk("no_err_yet", {31'd0, biu_proto_err}, 32'h0);

    // Write beats read within LSU; write fields held while inputs change
    lsu_biu_wr_req = 1; lsu_biu_wr_addr = 32'h80000010; lsu_biu_wr_size = 3'd2;
    lsu_biu_wr_data = 32'hDEADBEEF; lsu_biu_wr_strb = 4'hF;
    lsu_biu_rd_req = 1; lsu_biu_rd_addr = 32'h80000300; lsu_biu_rd_size = 3'd0;
    tick();
    chk("wr_gnts", gnts(), 32'b00101);
    chk("wr_data", arb_wr_data, 32'hDEADBEEF);
    chk("wr_addr", arb_wr_addr, 32'h80000010);
    chk("wr_fields", {16'd0, arb_wr_id, arb_wr_strb, arb_wr_size, arb_wr_last},
        {16'd0, 4'h1, 4'hF, 3'd2, 1'b1});
    chk("wr_len", {24'd0, arb_wr_len}, 32'h0);
    lsu_biu_wr_req = 0; lsu_biu_wr_data = 32'h12345678; lsu_biu_wr_strb = 4'h3;
    tick();
    chk("wr_pulse_end", gnts(), 32'h0);
    chk("wr_data_hold", arb_wr_data, 32'hDEADBEEF);
    tick();
    chk("wr_strb_hold", {28'd0, arb_wr_strb}, 32'hF);
    axi_write_lsu_val = 1; tick(); axi_write_lsu_val = 0;
    chk("wr_done_gap", gnts(), 32'h0);
    tick();
    chk("rd_after_wr_gnts", gnts(), 32'b01010);
    chk("rd_after_wr_addr", arb_rd_addr, 32'h80000300);
    lsu_biu_rd_req = 0;
    axi_rdata_lsu_val = 1; tick(); axi_rdata_lsu_val = 0;
    tick();

    // Timeout after 8 cycles with no completion; late completion is stray
    ifu_biu_rd_req = 1; ifu_biu_rd_addr = 32'h1C000040;
    tick();
    chk("to_gnts", gnts(), 32'b10010);
    ifu_biu_rd_req = 0;
    for (int i = 1; i < 8; i++) begin
      tick();
      chk($sformatf("to_quiet_%0d", i), {31'd0, biu_timeout}, 32'h0);
    end
    tick();
    chk("to_pulse", {31'd0, biu_timeout}, 32'h1);
    chk("to_no_regrant", gnts(), 32'h0);
    tick();
    chk("to_pulse_end", {31'd0, biu_timeout}, 32'h0);
    axi_rdata_ifu_val = 1; tick(); axi_rdata_ifu_val = 0;
    chk("stray_err", {31'd0, biu_proto_err}, 32'h1);
    tick();
    chk("stray_err_sticky", {31'd0, biu_proto_err}, 32'h1);
    chk("stray_no_gnt", gnts(), 32'h0);

    // Async reset mid-write, then IFU wins the first tie
    lsu_biu_wr_req = 1; lsu_biu_wr_data = 32'hCAFEF00D;
    tick();
    chk("rst_wr_gnt", gnts(), 32'b00101);
    lsu_biu_wr_req = 0;
    tick();
    #2 resetn = 1'b0;
    #1;
    chk("async_wr_data", arb_wr_data, 32'h0);
    chk("async_rd_addr", arb_rd_addr, 32'h0);
    chk("async_err", {31'd0, biu_proto_err}, 32'h0);
    ifu_biu_rd_req = 1; lsu_biu_rd_req = 1; lsu_biu_wr_req = 0;
    tick();
    chk("in_reset_no_gnt", gnts(), 32'h0);
    #2 resetn = 1'b1;
    tick();
    chk("post_rst_ifu_first", gnts(), 32'b10010);
    ifu_biu_rd_req = 0; lsu_biu_rd_req = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
